// File: rtl/datapath_seq.sv
// datapath_seq: register file, B shifter, ALU and A/B/C/status registers sequenced by an internal FSM.
// Latency from the start edge to done: ALU ops 5, CMP 4, MOVI 2, NOP 1 cycles. N/V flags only with DATAPATH_SEQ_NV_FLAGS_EN.
// Backpressure: start is sampled only while busy=0; a start seen while busy is dropped, not queued.
module datapath_seq #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int RW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [RW-1:0]    rd,
    input  logic [RW-1:0]    rn,
    input  logic [RW-1:0]    rm,
    input  logic [1:0]       shift,
    input  logic [WIDTH-1:0] imm,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] datapath_out,
    output logic [2:0]       status
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RDA  = 3'd1;
    localparam logic [2:0] S_RDB  = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [2:0] OP_MOVI = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_CMP  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVN  = 3'b101;

    logic [2:0]                  state_q;
    logic [2:0]                  state_nxt;
    logic                        accept;

    logic [2:0]                  op_q;
    logic [RW-1:0]               rd_q;
    logic [RW-1:0]               rn_q;
    logic [RW-1:0]               rm_q;
    logic [1:0]                  shift_q;
    logic [WIDTH-1:0]            imm_q;

    logic [NREGS-1:0][WIDTH-1:0] rf;
    logic [WIDTH-1:0]            a_q;
    logic [WIDTH-1:0]            b_q;
    logic [WIDTH-1:0]            c_q;
    logic [2:0]                  status_q;

    logic [WIDTH-1:0]            sh_b;
    logic [WIDTH-1:0]            alu_res;
    logic                        alu_wr_c;
    logic                        flag_z;
    logic                        flag_n;
    logic                        flag_v;
    logic                        rf_we;
    logic [WIDTH-1:0]            rf_wdat;

    assign accept = (state_q == S_IDLE) && start;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MOVI)
                        state_nxt = S_WB;
                    else if (op[2:1] == 2'b11)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_RDA;
                end
            end
            S_RDA:   state_nxt = S_RDB;
            S_RDB:   state_nxt = S_EXEC;
            S_EXEC:  state_nxt = (op_q == OP_CMP) ? S_DONE : S_WB;
            S_WB:    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shifter works on the registered B operand so EXEC sees a stable value.
    always_comb begin
        sh_b = b_q;
        case (shift_q)
            2'b01:   sh_b = {b_q[WIDTH-2:0], 1'b0};
            2'b10:   sh_b = {1'b0, b_q[WIDTH-1:1]};
            2'b11:   sh_b = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
            default: sh_b = b_q;
        endcase
    end

    always_comb begin
        alu_res  = '0;
        alu_wr_c = 1'b1;
        case (op_q)
            OP_MOV: alu_res = sh_b;
            OP_ADD: alu_res = a_q + sh_b;
            OP_CMP: begin
                alu_res  = a_q - sh_b;
                alu_wr_c = 1'b0;
            end
            OP_AND: alu_res = a_q & sh_b;
            OP_MVN: alu_res = ~sh_b;
            default: alu_wr_c = 1'b0;
        endcase
    end

    assign flag_z = (alu_res == '0);

`ifdef DATAPATH_SEQ_NV_FLAGS_EN
    assign flag_n = alu_res[WIDTH-1];

    // Signed overflow: operand signs vs. result sign, with B inverted for the subtract.
    always_comb begin
        flag_v = 1'b0;
        case (op_q)
            OP_ADD:  flag_v = (a_q[WIDTH-1] == sh_b[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            OP_CMP:  flag_v = (a_q[WIDTH-1] != sh_b[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            default: flag_v = 1'b0;
        endcase
    end
`else
    assign flag_n = 1'b0;
    assign flag_v = 1'b0;
`endif

    assign rf_we   = (state_q == S_WB);
    assign rf_wdat = (op_q == OP_MOVI) ? imm_q : c_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            shift_q  <= '0;
            imm_q    <= '0;
            rf       <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                op_q    <= op;
                rd_q    <= rd;
                rn_q    <= rn;
                rm_q    <= rm;
                shift_q <= shift;
                imm_q   <= imm;
            end
            if (state_q == S_RDA)
                a_q <= rf[rn_q];
            if (state_q == S_RDB)
                b_q <= rf[rm_q];
            if (state_q == S_EXEC) begin
                status_q <= {flag_v, flag_n, flag_z};
                if (alu_wr_c)
                    c_q <= alu_res;
            end
            if (rf_we)
                rf[rd_q] <= rf_wdat;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign datapath_out = c_q;
    assign status       = status_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: directed scenarios plus random instruction streams against an arithmetic reference model.
module tb_datapath_seq;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;

    localparam logic [2:0] OP_MOVI = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_CMP  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVN  = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;

`ifdef DATAPATH_SEQ_NV_FLAGS_EN
    localparam bit NV_EN = 1'b1;
`else
    localparam bit NV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [2:0]  rd = '0;
    logic [2:0]  rn = '0;
    logic [2:0]  rm = '0;
    logic [1:0]  shift = '0;
    logic [15:0] imm = '0;
    logic        busy;
    logic        done;
    logic [15:0] datapath_out;
    logic [2:0]  status;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] m_rf [NREGS];
    logic [15:0] m_c;
    logic [2:0]  m_st;

    datapath_seq #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .op           (op),
        .rd           (rd),
        .rn           (rn),
        .rm           (rm),
        .shift        (shift),
        .imm          (imm),
        .busy         (busy),
        .done         (done),
        .datapath_out (datapath_out),
        .status       (status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int to_signed(input int u);
        return (u >= 32768) ? u - 65536 : u;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_rf[i] = 16'h0;
        m_c  = 16'h0;
        m_st = 3'b000;
    endtask

    // Reference model: unsigned integer arithmetic on 16-bit words, overflow from true signed range.
    task automatic model_step(input logic [2:0] o, input int d, input int n, input int m,
                              input logic [1:0] s, input logic [15:0] im, output int elat);
        int a, b, sh, res, sres;
        logic z, ng, v;
        a = int'(m_rf[n]);
        b = int'(m_rf[m]);
        case (s)
            2'd0:    sh = b;
            2'd1:    sh = (b * 2) % 65536;
            2'd2:    sh = b / 2;
            default: sh = b / 2 + ((b >= 32768) ? 32768 : 0);
        endcase
        res = 0; sres = 0; v = 1'b0;
        if (o == OP_MOVI) begin
            m_rf[d] = im;
            elat = 2;
        end else if (o >= OP_NOP) begin
            elat = 1;
        end else begin
            case (o)
                OP_MOV: res = sh;
                OP_ADD: begin
                    res  = (a + sh) % 65536;
                    sres = to_signed(a) + to_signed(sh);
                    v    = (sres > 32767) || (sres < -32768);
                end
                OP_CMP: begin
                    res  = (a - sh + 65536) % 65536;
                    sres = to_signed(a) - to_signed(sh);
                    v    = (sres > 32767) || (sres < -32768);
                end
                OP_AND: res = a & sh;
                default: res = 65535 - sh;
            endcase
            z    = (res == 0);
            ng   = (res >= 32768);
            m_st = {v & NV_EN, ng & NV_EN, z};
            if (o == OP_CMP) begin
                elat = 4;
            end else begin
                m_c     = 16'(res);
                m_rf[d] = 16'(res);
                elat    = 5;
            end
        end
    endtask

    // Drives one instruction through the handshake; lat = cycles from accept edge to done (-1 on timeout).
    task automatic issue(input logic [2:0] o, input int d, input int n, input int m,
                         input logic [1:0] s, input logic [15:0] im,
                         output int elat, output int lat, output logic b1, output logic da, output int ta);
        model_step(o, d, n, m, s, im, elat);
        op = o; rd = 3'(d); rn = 3'(n); rm = 3'(m); shift = s; imm = im;
        start = 1'b1;
        @(posedge clk); #1;
        ta = cyc;
        start = 1'b0;
        b1 = busy;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        da = done;
    endtask

    task automatic test_reset();
        int elat, lat, ta;
        logic b1, da;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        if (datapath_out !== 16'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0000", datapath_out); end
        if (status !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b want 000", status); end
        for (int r = NREGS - 1; r >= 0; r--) begin
            issue(OP_MOV, 1, 0, r, 2'b00, 16'h0, elat, lat, b1, da, ta);
            n_checks += 2;
            if (datapath_out !== 16'h0) begin n_fail++; $display("FAIL reset_reg[%0d]: got %h want 0000", r, datapath_out); end
            if (lat !== elat) begin n_fail++; $display("FAIL reset_lat[%0d]: got %0d want %0d", r, lat, elat); end
        end
    endtask

    task automatic test_add();
        int elat, lat, ta;
        logic b1, da;
        issue(OP_MOVI, 2, 0, 0, 2'b00, 16'd202, elat, lat, b1, da, ta);
        n_checks += 2;
        if (lat !== 2) begin n_fail++; $display("FAIL movi_lat: got %0d want 2", lat); end
        if (datapath_out !== 16'h0) begin n_fail++; $display("FAIL movi_hold_out: got %h want 0000", datapath_out); end
        issue(OP_MOVI, 4, 0, 0, 2'b00, 16'd51, elat, lat, b1, da, ta);
        issue(OP_ADD, 5, 2, 4, 2'b01, 16'h0, elat, lat, b1, da, ta);
        n_checks += 6;
        if (lat !== 5) begin n_fail++; $display("FAIL add_lat: got %0d want 5", lat); end
        if (datapath_out !== 16'd304) begin n_fail++; $display("FAIL add_out: got %0d want 304", datapath_out); end
        if (status[0] !== 1'b0) begin n_fail++; $display("FAIL add_z: got %b want 0", status[0]); end
        if (status !== m_st) begin n_fail++; $display("FAIL add_status: got %b want %b", status, m_st); end
        if (b1 !== 1'b1) begin n_fail++; $display("FAIL add_busy: got %b want 1", b1); end
        if (da !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b want 0", da); end
    endtask

    task automatic test_cmp();
        int elat, lat, ta;
        logic b1, da;
        issue(OP_CMP, 0, 2, 2, 2'b00, 16'h0, elat, lat, b1, da, ta);
        n_checks += 3;
        if (lat !== 4) begin n_fail++; $display("FAIL cmp_lat: got %0d want 4", lat); end
        if (status !== 3'b001) begin n_fail++; $display("FAIL cmp_status: got %b want 001", status); end
        if (datapath_out !== 16'd304) begin n_fail++; $display("FAIL cmp_out_hold: got %0d want 304", datapath_out); end
        issue(OP_MOV, 6, 0, 5, 2'b00, 16'h0, elat, lat, b1, da, ta);
        n_checks += 2;
        if (datapath_out !== 16'd304) begin n_fail++; $display("FAIL cmp_r5_kept: got %0d want 304", datapath_out); end
        if (status !== m_st) begin n_fail++; $display("FAIL mov_status: got %b want %b", status, m_st); end
    endtask

    task automatic test_overflow();
        int elat, lat, ta;
        logic b1, da;
        issue(OP_MOVI, 0, 0, 0, 2'b00, 16'h7FFF, elat, lat, b1, da, ta);
        issue(OP_MOVI, 1, 0, 0, 2'b00, 16'h0001, elat, lat, b1, da, ta);
        issue(OP_ADD, 3, 0, 1, 2'b00, 16'h0, elat, lat, b1, da, ta);
        n_checks += 2;
        if (datapath_out !== 16'h8000) begin n_fail++; $display("FAIL ovf_out: got %h want 8000", datapath_out); end
        if (status !== (NV_EN ? 3'b110 : 3'b000)) begin
            n_fail++; $display("FAIL ovf_status: got %b want %b", status, (NV_EN ? 3'b110 : 3'b000));
        end
    endtask

    task automatic test_shifts();
        int elat, lat, ta;
        logic b1, da;
        logic [1:0]  sh_tab [3] = '{2'b11, 2'b10, 2'b01};
        logic [15:0] exp_tab [3] = '{16'hC001, 16'h4001, 16'h0004};
        for (int k = 0; k < 3; k++) begin
            issue(OP_MOVI, 1, 0, 0, 2'b00, 16'h8002, elat, lat, b1, da, ta);
            issue(OP_MOV, 1, 0, 1, sh_tab[k], 16'h0, elat, lat, b1, da, ta);
            n_checks += 2;
            if (datapath_out !== exp_tab[k]) begin n_fail++; $display("FAIL shift[%0d]: got %h want %h", k, datapath_out, exp_tab[k]); end
            if (status !== m_st) begin n_fail++; $display("FAIL shift_status[%0d]: got %b want %b", k, status, m_st); end
        end
    endtask

    task automatic test_ignore_start();
        int elat, lat, ta, ndone;
        logic b1, da;
        model_step(OP_ADD, 3, 5, 5, 2'b00, 16'h0, elat);
        op = OP_ADD; rd = 3'd3; rn = 3'd5; rm = 3'd5; shift = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        op = OP_MOVI; rd = 3'd5; imm = 16'h1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        n_checks += 3;
        if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
        if (datapath_out !== m_c) begin n_fail++; $display("FAIL ignore_out: got %h want %h", datapath_out, m_c); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: got busy=%b want 0", busy); end
        issue(OP_MOV, 7, 0, 5, 2'b00, 16'h0, elat, lat, b1, da, ta);
        n_checks += 1;
        if (datapath_out !== m_c) begin n_fail++; $display("FAIL ignore_r5: got %h want %h", datapath_out, m_c); end
    endtask

    task automatic test_back_to_back();
        int elat, lat, ta, prev_ta, prev_elat;
        logic b1, da;
        logic [2:0] seq [10] = '{OP_ADD, OP_CMP, OP_MOVI, OP_NOP, OP_MOV, 3'b111, OP_NOP, OP_MOVI, OP_CMP, OP_MVN};
        prev_ta = 0; prev_elat = 0;
        for (int k = 0; k < 10; k++) begin
            issue(seq[k], k % NREGS, (k + 3) % NREGS, (k + 5) % NREGS, 2'(k), 16'(k * 4099), elat, lat, b1, da, ta);
            n_checks += 3;
            if (lat !== elat) begin n_fail++; $display("FAIL b2b_lat[%0d]: got %0d want %0d", k, lat, elat); end
            if (b1 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy[%0d]: got %b want 1", k, b1); end
            if (k > 0 && (ta - prev_ta) !== prev_elat + 1) begin
                n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", k, ta - prev_ta, prev_elat + 1);
            end
            prev_ta = ta; prev_elat = elat;
        end
    endtask

    task automatic test_random();
        int elat, lat, ta;
        logic b1, da;
        logic [2:0] o;
        logic [15:0] im;
        for (int k = 0; k < 120; k++) begin
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       im = 16'h7FFF;
                1:       im = 16'h8000;
                default: im = 16'($urandom);
            endcase
            issue(o, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  2'($urandom_range(0, 3)), im, elat, lat, b1, da, ta);
            n_checks += 4;
            if (lat !== elat) begin n_fail++; $display("FAIL rand_lat[%0d] op=%0d: got %0d want %0d", k, o, lat, elat); end
            if (datapath_out !== m_c) begin n_fail++; $display("FAIL rand_out[%0d] op=%0d: got %h want %h", k, o, datapath_out, m_c); end
            if (status !== m_st) begin n_fail++; $display("FAIL rand_status[%0d] op=%0d: got %b want %b", k, o, status, m_st); end
            if (da !== 1'b0) begin n_fail++; $display("FAIL rand_done_pulse[%0d]: got %b want 0", k, da); end
        end
    endtask

    task automatic test_reset_mid();
        int elat, lat, ta, ndone;
        logic b1, da;
        issue(OP_MOVI, 2, 0, 0, 2'b00, 16'h0101, elat, lat, b1, da, ta);
        issue(OP_MOVI, 4, 0, 0, 2'b00, 16'h0202, elat, lat, b1, da, ta);
        issue(OP_ADD, 1, 2, 4, 2'b00, 16'h0, elat, lat, b1, da, ta);
        n_checks += 1;
        if (datapath_out !== 16'h0303) begin n_fail++; $display("FAIL pre_reset_out: got %h want 0303", datapath_out); end
        op = OP_ADD; rd = 3'd6; rn = 3'd2; rm = 3'd4; shift = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
        if (datapath_out !== 16'h0) begin n_fail++; $display("FAIL midrst_out: got %h want 0000", datapath_out); end
        if (status !== 3'b000) begin n_fail++; $display("FAIL midrst_status: got %b want 000", status); end
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        n_checks += 1;
        if (ndone !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d want 0", ndone); end
        for (int r = 1; r < NREGS; r++) begin
            issue(OP_MOV, 0, 0, r, 2'b00, 16'h0, elat, lat, b1, da, ta);
            n_checks += 1;
            if (datapath_out !== 16'h0) begin n_fail++; $display("FAIL midrst_reg[%0d]: got %h want 0000", r, datapath_out); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_cmp();
        test_overflow();
        test_shifts();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
